// File: rtl/matmul_result_stream_pkg.sv
// rtl/matmul_result_stream_pkg.sv - shared FSM encoding and width/slice helpers for the result stream
package matmul_result_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int max_dim(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  function automatic int elem_width(input int data_width);
    return 2 * data_width;
  endfunction

  // Bit offset of element (row, col) in a row-major packed square matrix.
  function automatic int elem_lsb(input int row, input int col, input int dim, input int ew);
    return (row * dim + col) * ew;
  endfunction

endpackage

// File: rtl/matmul_bias_adder.sv
// rtl/matmul_bias_adder.sv - element-wise signed bias add with overflow detect
// Saturates on overflow when MATMUL_RESULT_SATURATE_EN is defined, otherwise wraps.
module matmul_bias_adder #(
  parameter int ELEM_WIDTH = 16,
  parameter int NUM_ELEMS  = 4
) (
  input  logic                            add_en,
  input  logic [NUM_ELEMS*ELEM_WIDTH-1:0] a,
  input  logic [NUM_ELEMS*ELEM_WIDTH-1:0] b,
  output logic [NUM_ELEMS*ELEM_WIDTH-1:0] sum,
  output logic [NUM_ELEMS-1:0]            ovf
);

  for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_elem
    logic [ELEM_WIDTH-1:0] av;
    logic [ELEM_WIDTH-1:0] bv;
    logic [ELEM_WIDTH-1:0] sv;

    assign av = a[k*ELEM_WIDTH +: ELEM_WIDTH];
    assign bv = add_en ? b[k*ELEM_WIDTH +: ELEM_WIDTH] : '0;
    assign sv = av + bv;
    // Same-sign addends whose sum flips sign have left the representable range.
    assign ovf[k] = (av[ELEM_WIDTH-1] == bv[ELEM_WIDTH-1]) && (sv[ELEM_WIDTH-1] != av[ELEM_WIDTH-1]);

`ifdef MATMUL_RESULT_SATURATE_EN
    assign sum[k*ELEM_WIDTH +: ELEM_WIDTH] = !ovf[k]          ? sv :
                                             av[ELEM_WIDTH-1] ? {1'b1, {(ELEM_WIDTH-1){1'b0}}} :
                                                                {1'b0, {(ELEM_WIDTH-1){1'b1}}};
`else
    assign sum[k*ELEM_WIDTH +: ELEM_WIDTH] = sv;
`endif
  end

endmodule

// File: rtl/matmul_result_stream.sv
// rtl/matmul_result_stream.sv - captures matmul result (+bias), streams rows to scratchpad
// Optional saturation of bias-add overflow via MATMUL_RESULT_SATURATE_EN.
module matmul_result_stream
  import matmul_result_stream_pkg::*;
#(
  parameter int  DATA_WIDTH    = 8,
  parameter int  BUS_WIDTH     = 16,
  parameter int  SP_ADDR_WIDTH = 8,
  localparam int MAX_DIM       = max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int EW            = elem_width(DATA_WIDTH),
  localparam int DIM_WIDTH     = $clog2(MAX_DIM) + 1,
  localparam int NE            = MAX_DIM * MAX_DIM
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     mul_done_i,
  input  logic [NE*EW-1:0]         c_matrix_i,
  input  logic [NE-1:0]            c_flags_i,
  input  logic [NE*EW-1:0]         c_bias_i,
  input  logic                     mode_i,
  input  logic [DIM_WIDTH-1:0]     n_dim_i,
  input  logic [DIM_WIDTH-1:0]     m_dim_i,
  input  logic [SP_ADDR_WIDTH-1:0] sp_base_addr_i,
  input  logic                     sp_ready_i,
  output logic                     sp_we_o,
  output logic [SP_ADDR_WIDTH-1:0] sp_addr_o,
  output logic [MAX_DIM*EW-1:0]    sp_row_o,
  output logic [NE-1:0]            flags_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     overrun_o
);

  state_e                   state_q, state_d;
  logic [NE*EW-1:0]         res_q;
  logic [NE*EW-1:0]         sum;
  logic [NE-1:0]            flags_q;
  logic [NE-1:0]            add_ovf;
  logic [DIM_WIDTH-1:0]     n_q, m_q, row_q;
  logic [SP_ADDR_WIDTH-1:0] base_q;
  logic                     overrun_q;
  logic                     capture;
  logic                     accept;

  matmul_bias_adder #(
    .ELEM_WIDTH(EW),
    .NUM_ELEMS (NE)
  ) u_bias_adder (
    .add_en(mode_i),
    .a     (c_matrix_i),
    .b     (c_bias_i),
    .sum   (sum),
    .ovf   (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mul_done_i) begin
          capture = 1'b1;
          // A zero dimension is illegal: report completion without writing anything.
          state_d = (n_dim_i == '0 || m_dim_i == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (sp_ready_i) begin
          accept = 1'b1;
          if (row_q == n_q - DIM_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      res_q     <= '0;
      flags_q   <= '0;
      n_q       <= '0;
      m_q       <= '0;
      row_q     <= '0;
      base_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= mul_done_i && (state_q != ST_IDLE);
      if (capture) begin
        res_q   <= sum;
        flags_q <= c_flags_i | add_ovf;
        n_q     <= n_dim_i;
        m_q     <= m_dim_i;
        base_q  <= sp_base_addr_i;
        row_q   <= '0;
      end else if (accept) begin
        row_q <= row_q + DIM_WIDTH'(1);
      end
    end
  end

  always_comb begin
    sp_row_o = '0;
    if (state_q == ST_WRITE) begin
      for (int j = 0; j < MAX_DIM; j++) begin
        if (int'(row_q) < MAX_DIM && j < int'(m_q))
          sp_row_o[j*EW +: EW] = res_q[elem_lsb(int'(row_q), j, MAX_DIM, EW) +: EW];
      end
    end
  end

  assign sp_we_o   = (state_q == ST_WRITE);
  assign sp_addr_o = (state_q == ST_WRITE) ? base_q + SP_ADDR_WIDTH'(row_q) : '0;
  assign flags_o   = flags_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_matmul_result_stream.sv
// tb/tb_matmul_result_stream.sv - self-checking bench for matmul_result_stream (DATA_WIDTH=8, BUS_WIDTH=16)
module tb_matmul_result_stream;

  localparam int MD   = 2;
  localparam int NE   = 4;
  localparam int DIMW = 2;

  logic        clk_i;
  logic        rst_ni;
  logic        mul_done_i;
  logic [63:0] c_matrix_i;
  logic [3:0]  c_flags_i;
  logic [63:0] c_bias_i;
  logic        mode_i;
  logic [DIMW-1:0] n_dim_i;
  logic [DIMW-1:0] m_dim_i;
  logic [7:0]  sp_base_addr_i;
  logic        sp_ready_i;
  logic        sp_we_o;
  logic [7:0]  sp_addr_o;
  logic [31:0] sp_row_o;
  logic [3:0]  flags_o;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;

  matmul_result_stream dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .mul_done_i    (mul_done_i),
    .c_matrix_i    (c_matrix_i),
    .c_flags_i     (c_flags_i),
    .c_bias_i      (c_bias_i),
    .mode_i        (mode_i),
    .n_dim_i       (n_dim_i),
    .m_dim_i       (m_dim_i),
    .sp_base_addr_i(sp_base_addr_i),
    .sp_ready_i    (sp_ready_i),
    .sp_we_o       (sp_we_o),
    .sp_addr_o     (sp_addr_o),
    .sp_row_o      (sp_row_o),
    .flags_o       (flags_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overrun_o     (overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp;
  int n_err;

  // Model: pending writes of the accepted matrix plus the expected control outputs this cycle.
  logic [7:0]  q_addr[$];
  logic [31:0] q_row[$];
  bit          e_we, e_done, e_ovr, e_busy;
  logic [3:0]  e_flags;
  logic [7:0]  log_addr[$];
  logic [31:0] log_row[$];

`ifdef MATMUL_RESULT_SATURATE_EN
  localparam logic [31:0] T2_ROW0 = 32'h0002_7FFF;
`else
  localparam logic [31:0] T2_ROW0 = 32'h0002_8000;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic elem(input int k, output logic [15:0] v, output logic ovf);
    int a, b, s;
    a = int'($signed(c_matrix_i[k*16 +: 16]));
    b = mode_i ? int'($signed(c_bias_i[k*16 +: 16])) : 0;
    s = a + b;
    ovf = (s > 32767) || (s < -32768);
`ifdef MATMUL_RESULT_SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    v = s[15:0];
  endtask

  task automatic model_step();
    bit          nxt_done, nxt_ovr;
    logic        ovf;
    logic [15:0] v;
    logic [31:0] row;
    int          nrows, ncols;
    if (!rst_ni) begin
      q_addr.delete();
      q_row.delete();
      e_we = 0; e_done = 0; e_ovr = 0; e_busy = 0; e_flags = '0;
    end
    chk("sp_we", sp_we_o, e_we);
    chk("busy", busy_o, e_busy);
    chk("done", done_o, e_done);
    chk("overrun", overrun_o, e_ovr);
    chk("flags", flags_o, e_flags);
    if (e_we) begin
      chk("sp_addr", sp_addr_o, q_addr[0]);
      chk("sp_row", sp_row_o, q_row[0]);
    end
    if (rst_ni && sp_we_o && sp_ready_i) begin
      log_addr.push_back(sp_addr_o);
      log_row.push_back(sp_row_o);
    end
    if (!rst_ni) return;
    nxt_ovr  = mul_done_i && e_busy;
    nxt_done = 0;
    if (e_we && sp_ready_i) begin
      void'(q_addr.pop_front());
      void'(q_row.pop_front());
      if (q_addr.size() == 0) nxt_done = 1;
    end
    if (mul_done_i && !e_busy) begin
      nrows = int'(n_dim_i);
      ncols = int'(m_dim_i);
      e_flags = c_flags_i;
      for (int k = 0; k < NE; k++) begin
        elem(k, v, ovf);
        if (ovf) e_flags[k] = 1'b1;
      end
      if (nrows == 0 || ncols == 0) nxt_done = 1;
      else begin
        for (int r = 0; r < nrows; r++) begin
          row = '0;
          for (int j = 0; j < MD; j++) begin
            if (j < ncols) begin
              elem(r * MD + j, v, ovf);
              row[j*16 +: 16] = v;
            end
          end
          q_addr.push_back(sp_base_addr_i + 8'(r));
          q_row.push_back(row);
        end
      end
    end
    e_ovr  = nxt_ovr;
    e_done = nxt_done;
    e_we   = (q_addr.size() > 0);
    e_busy = e_we || e_done;
  endtask

  task automatic tick();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic capture(input logic [63:0] c, input logic [63:0] b, input logic [3:0] f,
                         input logic md, input logic [1:0] n, input logic [1:0] m, input logic [7:0] base);
    c_matrix_i = c; c_bias_i = b; c_flags_i = f; mode_i = md;
    n_dim_i = n; m_dim_i = m; sp_base_addr_i = base;
    mul_done_i = 1'b1;
    tick();
    mul_done_i = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy_o && i < 50) begin
      tick();
      i++;
    end
    chk("idle_timeout", busy_o, 0);
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [7:0] a, input logic [31:0] r);
    if (idx < log_addr.size()) begin
      chk({nm, "_addr"}, log_addr[idx], a);
      chk({nm, "_row"}, log_row[idx], r);
    end else begin
      chk({nm, "_present"}, log_addr.size(), idx + 1);
    end
  endtask

  initial begin
    logic [4:0] pat;
    n_cmp = 0; n_err = 0;
    rst_ni = 1'b0; mul_done_i = 1'b0; c_matrix_i = '0; c_flags_i = '0; c_bias_i = '0;
    mode_i = 1'b0; n_dim_i = '0; m_dim_i = '0; sp_base_addr_i = '0; sp_ready_i = 1'b1;
    e_we = 0; e_done = 0; e_ovr = 0; e_busy = 0; e_flags = '0;
    @(posedge clk_i); #1;
    chk("rst_we", sp_we_o, 0);
    chk("rst_addr", sp_addr_o, 0);
    chk("rst_row", sp_row_o, 0);
    chk("rst_flags", flags_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done_ovr", {done_o, overrun_o}, 0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // 2x2 pass-through, exact cycle placement
    log_addr.delete(); log_row.delete();
    capture(64'h0004_0003_0002_0001, '0, 4'b0000, 1'b0, 2'd2, 2'd2, 8'h10);
    chk("t1_we0", sp_we_o, 1);
    chk("t1_addr0", sp_addr_o, 8'h10);
    chk("t1_row0", sp_row_o, 32'h0002_0001);
    tick();
    chk("t1_addr1", sp_addr_o, 8'h11);
    chk("t1_row1", sp_row_o, 32'h0004_0003);
    tick();
    chk("t1_done", {done_o, sp_we_o}, 2'b10);
    tick();
    chk("t1_idle", busy_o, 0);
    chk("t1_flags", flags_o, 4'b0000);

    // bias add with overflow on element 0
    log_addr.delete(); log_row.delete();
    capture(64'h0005_FFFF_0001_7FFF, 64'h0001_0001_0001_0001, 4'b0000, 1'b1, 2'd2, 2'd2, 8'h40);
    wait_idle();
    chk("t2_nwrites", log_addr.size(), 2);
    chk_log("t2_w0", 0, 8'h40, T2_ROW0);
    chk_log("t2_w1", 1, 8'h41, 32'h0006_0000);
    chk("t2_flags", flags_o, 4'b0001);

    // 1x1 with core flag, column masking
    capture(64'h0004_0003_0002_0001, '0, 4'b1000, 1'b0, 2'd1, 2'd1, 8'h50);
    chk("t3_addr", sp_addr_o, 8'h50);
    chk("t3_row", sp_row_o, 32'h0000_0001);
    tick();
    chk("t3_done", done_o, 1);
    chk("t3_flags", flags_o, 4'b1000);
    wait_idle();

    // back-pressure 0,0,1,0,1
    log_addr.delete(); log_row.delete();
    sp_ready_i = 1'b0;
    capture(64'h0004_0003_0002_0001, '0, 4'b0000, 1'b0, 2'd2, 2'd2, 8'h60);
    pat = 5'b10100;
    for (int i = 0; i < 5; i++) begin
      sp_ready_i = pat[i];
      tick();
    end
    sp_ready_i = 1'b1;
    wait_idle();
    chk("t4_nwrites", log_addr.size(), 2);
    chk_log("t4_w0", 0, 8'h60, 32'h0002_0001);
    chk_log("t4_w1", 1, 8'h61, 32'h0004_0003);

    // overrun during WRITE, then a fresh capture after done
    log_addr.delete(); log_row.delete();
    capture(64'h0004_0003_0002_0001, '0, 4'b0000, 1'b0, 2'd2, 2'd2, 8'h20);
    c_matrix_i = 64'h0009_0009_0009_0009;
    mul_done_i = 1'b1;
    tick();
    mul_done_i = 1'b0;
    chk("t5_overrun", overrun_o, 1);
    chk("t5_row1", sp_row_o, 32'h0004_0003);
    wait_idle();
    capture(64'h0009_0009_0009_0009, '0, 4'b0000, 1'b0, 2'd1, 2'd2, 8'h30);
    wait_idle();
    chk_log("t5_w0", 0, 8'h20, 32'h0002_0001);
    chk_log("t5_w2", 2, 8'h30, 32'h0009_0009);

    // illegal zero dimension: done without writes
    log_addr.delete(); log_row.delete();
    capture(64'h0004_0003_0002_0001, '0, 4'b0010, 1'b0, 2'd0, 2'd2, 8'h70);
    chk("t6_done", {done_o, sp_we_o}, 2'b10);
    wait_idle();
    chk("t6_nwrites", log_addr.size(), 0);
    chk("t6_flags", flags_o, 4'b0010);

    // reset mid-stream, then address wrap
    log_addr.delete(); log_row.delete();
    sp_ready_i = 1'b0;
    capture(64'h0004_0003_0002_0001, '0, 4'b0110, 1'b0, 2'd2, 2'd2, 8'hFF);
    chk("t7_addr_pre", sp_addr_o, 8'hFF);
    rst_ni = 1'b0;
    #1;
    chk("t7_rst_we", sp_we_o, 0);
    chk("t7_rst_busy", busy_o, 0);
    chk("t7_rst_addr_row", {sp_addr_o, sp_row_o}, 0);
    chk("t7_rst_flags", flags_o, 0);
    tick(); tick();
    rst_ni = 1'b1;
    sp_ready_i = 1'b1;
    tick();
    chk("t7_no_writes", log_addr.size(), 0);
    capture(64'h0004_0003_0002_0001, '0, 4'b0000, 1'b0, 2'd2, 2'd2, 8'hFF);
    wait_idle();
    chk_log("t7_w0", 0, 8'hFF, 32'h0002_0001);
    chk_log("t7_w1", 1, 8'h00, 32'h0004_0003);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
